// File: rtl/div_radix2_seq.sv
// rtl/div_radix2_seq.sv - iterative radix-2 shift-subtract divider with RISC-V div/rem semantics
module div_radix2_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_flush,
    input  logic             div_valid,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_o_valid,
    input  logic             div_o_ready
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] dvsr;
    logic             q_neg;
    logic             r_neg;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             is_ovf;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;

    always_comb begin
        a_neg   = div_signed & dividend[WIDTH-1];
        b_neg   = div_signed & divisor[WIDTH-1];
        abs_a   = a_neg ? -dividend : dividend;
        abs_b   = b_neg ? -divisor : divisor;
        is_ovf  = div_signed && (dividend == MIN_VAL) && (&divisor);
        shifted = {part_rem, work[WIDTH-1]};
        diff    = shifted - {1'b0, dvsr};
        // A set top bit in the shifted remainder always exceeds the divisor,
        // otherwise the sign of the WIDTH+1-bit difference is the borrow.
        borrow  = ~shifted[WIDTH] & diff[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            part_rem    <= '0;
            work        <= '0;
            dvsr        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_o_valid <= 1'b0;
        end else if (div_flush) begin
            state       <= IDLE;
            cnt         <= '0;
            div_o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_valid) begin
                        q_neg    <= a_neg ^ b_neg;
                        r_neg    <= a_neg;
                        work     <= abs_a;
                        dvsr     <= abs_b;
                        part_rem <= '0;
                        cnt      <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_o_valid <= 1'b1;
                            state       <= DONE;
                        end else if (is_ovf) begin
                            quotient    <= dividend;
                            remainder   <= '0;
                            div_o_valid <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    work     <= {work[WIDTH-2:0], ~borrow};
                    part_rem <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    if (cnt == LAST_CNT) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    quotient    <= q_neg ? -work : work;
                    remainder   <= r_neg ? -part_rem : part_rem;
                    div_o_valid <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (div_o_ready) begin
                        div_o_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_radix2_seq.sv
// tb/tb_div_radix2_seq.sv - vector, corner-sequence and randomized checks for div_radix2_seq
module tb_div_radix2_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_flush;
    logic        div_valid;
    logic        div_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_o_valid;
    logic        div_o_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    always #5 clk = ~clk;

    div_radix2_seq #(.WIDTH(64), .CNT_W(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_flush   (div_flush),
        .div_valid   (div_valid),
        .div_signed  (div_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_o_valid (div_o_valid),
        .div_o_ready (div_o_ready)
    );

    typedef struct {
        logic        s;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference semantics from plain signed/unsigned arithmetic plus the RISC-V special cases.
    task automatic ref_div(input logic s, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] q, output logic [63:0] r, output int lat);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa  = a;
        sb  = b;
        lat = 66;
        if (b == 64'd0) begin
            q = ONES; r = a; lat = 1;
        end else if (s && a == MINV && b == ONES) begin
            q = a; r = 64'd0; lat = 1;
        end else if (s) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    // Issue one request, wait for the result, complete the handshake.
    task automatic do_op(input logic s, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r, output int lat);
        @(negedge clk);
        div_signed = s;
        dividend   = a;
        divisor    = b;
        div_valid  = 1'b1;
        lat        = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!div_o_valid && lat < 200);
        q = quotient;
        r = remainder;
        @(negedge clk);
        div_o_ready = 1'b1;
        div_valid   = 1'b0;
        @(posedge clk); #1;
        div_o_ready = 1'b0;
        chk("valid_low_after_handshake", 64'(div_o_valid), 64'd0);
    endtask

    task automatic count_valid(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (div_o_valid) hits++;
        end
    endtask

    logic [63:0] q, r, eq, er, hq, hr;
    int          lat, elat, hits;

    initial begin
        vecs[0] = '{1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 66};
        vecs[1] = '{1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 66};
        vecs[2] = '{1'b1, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66};
        vecs[3] = '{1'b1, 64'd5, 64'd0, ONES, 64'd5, 1};
        vecs[4] = '{1'b0, 64'd5, 64'd0, ONES, 64'd5, 1};
        vecs[5] = '{1'b1, MINV, ONES, MINV, 64'd0, 1};
        vecs[6] = '{1'b0, MINV, ONES, 64'd0, MINV, 66};
        vecs[7] = '{1'b1, -64'sd100, -64'sd7, 64'd14, ONES - 64'd1, 66};

        rst_n = 1'b0; div_flush = 1'b0; div_valid = 1'b0; div_signed = 1'b0;
        dividend = 64'd0; divisor = 64'd0; div_o_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(div_o_valid), 64'd0);
        chk("reset_quotient", quotient, 64'd0);
        chk("reset_remainder", remainder, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].s, vecs[i].a, vecs[i].b, q, r, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            chk($sformatf("vec%0d_remainder", i), r, vecs[i].r);
        end

        // Flush ten cycles into a calculation, then a fresh request.
        @(negedge clk);
        div_signed = 1'b0; dividend = 64'd1000; divisor = 64'd10; div_valid = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        div_flush = 1'b1; div_valid = 1'b0;
        @(posedge clk); #1;
        chk("flush_valid_low", 64'(div_o_valid), 64'd0);
        @(negedge clk);
        div_flush = 1'b0;
        do_op(1'b0, 64'd9, 64'd3, q, r, lat);
        chk("post_flush_latency", 64'(lat), 64'd66);
        chk("post_flush_quotient", q, 64'd3);
        chk("post_flush_remainder", r, 64'd0);

        // Flush together with a request in IDLE must not accept it.
        @(negedge clk);
        dividend = 64'd20; divisor = 64'd0; div_valid = 1'b1; div_flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0; div_flush = 1'b0;
        count_valid(70, hits);
        chk("flush_with_valid_no_accept", 64'(hits), 64'd0);

        // Back-pressure with toggling operands.
        @(negedge clk);
        div_signed = 1'b0; dividend = 64'd100; divisor = 64'd7; div_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!div_o_valid && lat < 200);
        chk("bp_latency", 64'(lat), 64'd66);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dividend   = {$urandom, $urandom};
            divisor    = {$urandom, $urandom};
            div_signed = 1'($urandom);
            @(posedge clk); #1;
            chk("bp_valid_held", 64'(div_o_valid), 64'd1);
            chk("bp_quotient_held", quotient, 64'd14);
            chk("bp_remainder_held", remainder, 64'd2);
        end
        @(negedge clk);
        div_o_ready = 1'b1; div_valid = 1'b0;
        @(posedge clk); #1;
        div_o_ready = 1'b0;
        chk("bp_single_transfer", 64'(div_o_valid), 64'd0);
        count_valid(5, hits);
        chk("bp_no_second_valid", 64'(hits), 64'd0);

        // Reset in the middle of a calculation.
        @(negedge clk);
        div_signed = 1'b0; dividend = 64'd12345; divisor = 64'd17; div_valid = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; div_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", 64'(div_o_valid), 64'd0);
        chk("midrst_quotient", quotient, 64'd0);
        chk("midrst_remainder", remainder, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_valid(70, hits);
        chk("midrst_no_result", 64'(hits), 64'd0);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            logic        s;
            logic [63:0] a, b;
            s = 1'($urandom);
            a = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0:       b = 64'd0;
                1:       b = 64'($urandom_range(1, 20));
                2:       b = -64'($urandom_range(1, 20));
                3:       begin a = MINV; b = ONES; end
                4:       b = {32'd0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            ref_div(s, a, b, eq, er, elat);
            do_op(s, a, b, hq, hr, lat);
            chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(elat));
            chk($sformatf("rnd%0d_quotient s=%0d a=%016h b=%016h", i, s, a, b), hq, eq);
            chk($sformatf("rnd%0d_remainder s=%0d a=%016h b=%016h", i, s, a, b), hr, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
